// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I decode stage producing the ALU control word for execute.
//
// Ports
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   flush                       drop every buffered entry on the next edge
//   in_valid/in_ready           fetch-side handshake; in_ready is registered (= !skid_valid)
//   in_inst, in_pc              instruction word and its address
//   out_valid/out_ready         execute-side handshake
//   alu_op, a_sel, b_sel, imm   ALU control word (a_sel 0=rs1 1=pc, b_sel 0=rs2 1=imm)
//   rd, rs1, rs2, reg_we        register fields (rd forced to 0 when reg_we=0)
//   illegal, out_pc             unsupported encoding flag, pc of the presented entry
//
// A main register presents the entry; a skid register catches the one entry accepted while
// main is stalled, so in_ready never depends combinationally on out_ready.
module alu_decode_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OP_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] alu_op,
  output logic            a_sel,
  output logic            b_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            reg_we,
  output logic            illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam logic [OP_W-1:0] OpAdd  = OP_W'(0);
  localparam logic [OP_W-1:0] OpSub  = OP_W'(1);
  localparam logic [OP_W-1:0] OpAnd  = OP_W'(2);
  localparam logic [OP_W-1:0] OpOr   = OP_W'(3);
  localparam logic [OP_W-1:0] OpXor  = OP_W'(4);
  localparam logic [OP_W-1:0] OpSlt  = OP_W'(5);
  localparam logic [OP_W-1:0] OpSltu = OP_W'(6);
  localparam logic [OP_W-1:0] OpSll  = OP_W'(7);
  localparam logic [OP_W-1:0] OpSra  = OP_W'(8);
  localparam logic [OP_W-1:0] OpSrl  = OP_W'(9);
  localparam logic [OP_W-1:0] OpCopyB = OP_W'(10);

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef struct packed {
    logic [OP_W-1:0] alu_op;
    logic            a_sel;
    logic            b_sel;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            reg_we;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } entry_t;

  // alt selects SUB (f3=000) or SRA (f3=101); ignored for other funct3 values.
  function automatic logic [OP_W-1:0] f3_op(input logic [2:0] f3, input logic alt);
    logic [OP_W-1:0] op;
    unique case (f3)
      3'b000:  op = alt ? OpSub : OpAdd;
      3'b001:  op = OpSll;
      3'b010:  op = OpSlt;
      3'b011:  op = OpSltu;
      3'b100:  op = OpXor;
      3'b101:  op = alt ? OpSra : OpSrl;
      3'b110:  op = OpOr;
      default: op = OpAnd;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm32;
  entry_t      dec;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21],
                  1'b0};

  always_comb begin
    dec         = '0;
    dec.alu_op  = OpAdd;
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.pc      = in_pc;
    imm32       = '0;
    unique case (opcode)
      OpcR: begin
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          dec.alu_op = f3_op(funct3, in_inst[30]);
          dec.reg_we = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OpcI: begin
        // No SUBI: only the shift-right encoding uses bit 30.
        dec.alu_op = f3_op(funct3, (funct3 == 3'b101) && in_inst[30]);
        dec.b_sel  = 1'b1;
        dec.reg_we = 1'b1;
        imm32      = imm_i;
      end
      OpcLui: begin
        dec.alu_op = OpCopyB;
        dec.b_sel  = 1'b1;
        dec.reg_we = 1'b1;
        imm32      = imm_u;
      end
      OpcAuipc: begin
        dec.a_sel  = 1'b1;
        dec.b_sel  = 1'b1;
        dec.reg_we = 1'b1;
        imm32      = imm_u;
      end
      OpcJal: begin
        dec.a_sel  = 1'b1;
        dec.b_sel  = 1'b1;
        dec.reg_we = 1'b1;
        imm32      = imm_j;
      end
      OpcJalr, OpcLoad: begin
        dec.b_sel  = 1'b1;
        dec.reg_we = 1'b1;
        imm32      = imm_i;
      end
      OpcStore: begin
        dec.b_sel = 1'b1;
        imm32     = imm_s;
      end
      OpcBranch: begin
        // ALU forms the branch target; the comparison happens elsewhere.
        dec.a_sel = 1'b1;
        dec.b_sel = 1'b1;
        imm32     = imm_b;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
    dec.rd  = dec.reg_we ? in_inst[11:7] : 5'd0;
  end

  // ---------------------------------------------------------------- main + skid buffer
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, emit;

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign emit     = main_valid_q && out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full implies main full and in_ready low: only a drain can happen.
      if (emit) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || emit) begin
      main_valid_d = accept;
      if (accept) main_d = dec;
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign alu_op    = main_q.alu_op;
  assign a_sel     = main_q.a_sel;
  assign b_sel     = main_q.b_sel;
  assign imm       = main_q.imm;
  assign rd        = main_q.rd;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign reg_we    = main_q.reg_we;
  assign illegal   = main_q.illegal;
  assign out_pc    = main_q.pc;

endmodule
